btb_pc_predictor: RTL
=====================

Name: btb_pc_predictor

Overview:
- Successor to the fetch-stage PC-select logic. Adds a direct-mapped branch target buffer (BTB) with 2-bit saturating counters, so taken branches and jumps can be predicted at fetch.
- Resolves redirects with a fixed priority: C-stage mispredict first, then unpredicted R-stage jump, then BTB prediction, then PC+4.
- Sits in stage 1 (Instruction). It is updated from the C stage and produces the PredictionCorrect/flush information that the hazard unit consumes.

Parameters:
- BIT_COUNT, 32, datapath/PC width.
- ENTRY_COUNT, 16, number of BTB entries. Must be a power of 2 and at least 2.
- INDEX_BITS, $clog2(ENTRY_COUNT), derived. Do not override.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- PC_I  input  BIT_COUNT  PC of the instruction being fetched.
- PCp4  input  BIT_COUNT  PC_I+4.
- Resolve_C  input  1  branch/jump resolving in C this cycle.
- IsJump_C  input  1  resolving instruction is an unconditional jump (JAL/JALR).
- Taken_C  input  1  actual direction; always 1 for jumps.
- ResolvePC_C  input  BIT_COUNT  PC of the resolving instruction.
- Target_C  input  BIT_COUNT  actual target (UpdatedPC/AluAdd).
- PredTaken_C  input  1  Predict value carried down the pipe with this instruction.
- PredTarget_C  input  BIT_COUNT  Prediction value carried down the pipe.
- Jump_R  input  1  JAL decoded in R.
- PredTaken_R  input  1  the R-stage instruction was predicted taken at fetch.
- PCpImm_R  input  BIT_COUNT  JAL target computed in R.
- Predict  output  1  BTB predicts taken for PC_I.
- Prediction  output  BIT_COUNT  predicted target; bit0 = 0.
- Mispredict_C  output  1  flush request for younger stages.
- PCNext  output  BIT_COUNT  next fetch PC; bit0 always 0.

Behaviour:
- Entry fields: valid, tag = PC[BIT_COUNT-1:INDEX_BITS+2], target[BIT_COUNT-1:0], ctr[1:0], jmp.
- Lookup index = PC_I[INDEX_BITS+1:2]. Lookup is combinational, zero latency.
- Hit = valid && tag match.
- Predict = Hit && (jmp || ctr >= 2'b10). Prediction = target with bit0 cleared. When there is no prediction, Prediction = 0.
- Mispredict_C = Resolve_C && ((PredTaken_C != Taken_C) || (Taken_C && PredTarget_C[BIT_COUNT-1:1] != Target_C[BIT_COUNT-1:1])).
- PCNext priority, bit0 forced to 0 in every case:
  1. Mispredict_C: Taken_C ? Target_C : ResolvePC_C + 4. The +4 wraps modulo 2^BIT_COUNT.
  2. Jump_R && !PredTaken_R: PCpImm_R.
  3. Predict: Prediction.
  4. Otherwise: PCp4.
- A correctly predicted C-stage instruction does not block R-stage redirection (level 2 still applies).
- Update happens on the rising edge when Resolve_C = 1, using index and tag from ResolvePC_C:
  - Hit, taken: ctr saturating increment (2'b11 holds), target <= Target_C, jmp <= IsJump_C.
  - Hit, not taken: ctr saturating decrement (2'b00 holds). Entry stays valid.
  - Miss, taken: allocate (overwriting any occupant). valid = 1, tag, target, jmp = IsJump_C, ctr = IsJump_C ? 2'b11 : 2'b10.
  - Miss, not taken: no change.
- Simultaneous lookup and update of the same index: lookup returns the pre-update contents (read-before-write). The new contents are visible the next cycle.
- Reset, including assertion mid-operation: all valid, ctr, target, tag and jmp fields are cleared to 0 immediately.
  - Predict = 0 and Prediction = 0.
  - PCNext then follows the combinational priority from its inputs (PCp4 when no redirect is active).
- All outputs are combinational from state and inputs. There are no output registers.

Optional Feature:
- Macro: BTB_PERF_CNT_EN.
- Defined: adds outputs LookupCount[31:0] and MispredictCount[31:0].
  - LookupCount increments on each cycle where Resolve_C = 1.
  - MispredictCount increments on each cycle where Mispredict_C = 1.
  - Both wrap at 2^32 and reset asynchronously to 0.
- Undefined: neither port nor counter exists. Behaviour is otherwise identical.

Test Plan:
- After reset, PC_I = 0x100, PCp4 = 0x104, no resolve/jump -> Predict = 0, PCNext = 0x104.
- Resolve_C at ResolvePC_C = 0x100, taken, Target_C = 0x200, PredTaken_C = 0 -> Mispredict_C = 1 and PCNext = 0x200. Next cycle with PC_I = 0x100: Predict = 1, Prediction = 0x200 (ctr = 2'b10).
- Same entry, then a not-taken resolve with PredTaken_C = 1 -> Mispredict_C = 1, PCNext = 0x104. Entry stays valid; ctr = 2'b01, so the next lookup of 0x100 gives Predict = 0. Two further taken resolves drive ctr to 2'b11.
- Predicted-correct C (PredTaken_C = 1, Taken_C = 1, targets equal) together with Jump_R = 1, PredTaken_R = 0, PCpImm_R = 0x301 -> Mispredict_C = 0, PCNext = 0x300.
- Alias: ENTRY_COUNT = 16, allocate 0x100, then a taken resolve at 0x140 (same index) -> lookup of 0x100 misses; 0x140 hits with its new target. Lookup and update of the same index in one cycle returns the old data.
- Reset asserted asynchronously mid-stream with a valid entry -> Predict drops to 0 before the next edge. With BTB_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/btb_pc_predictor.sv
// Fetch PC select with a direct-mapped BTB and 2-bit counters, updated from the C stage.
// Optional `BTB_PERF_CNT_EN adds LookupCount / MispredictCount outputs.
module btb_pc_predictor #(
  parameter int BIT_COUNT   = 32,
  parameter int ENTRY_COUNT = 16,
  parameter int INDEX_BITS  = $clog2(ENTRY_COUNT)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [BIT_COUNT-1:0] PC_I,
  input  logic [BIT_COUNT-1:0] PCp4,
  input  logic                 Resolve_C,
  input  logic                 IsJump_C,
  input  logic                 Taken_C,
  input  logic [BIT_COUNT-1:0] ResolvePC_C,
  input  logic [BIT_COUNT-1:0] Target_C,
  input  logic                 PredTaken_C,
  input  logic [BIT_COUNT-1:0] PredTarget_C,
  input  logic                 Jump_R,
  input  logic                 PredTaken_R,
  input  logic [BIT_COUNT-1:0] PCpImm_R,
`ifdef BTB_PERF_CNT_EN
  output logic [31:0]          LookupCount,
  output logic [31:0]          MispredictCount,
`endif
  output logic                 Predict,
  output logic [BIT_COUNT-1:0] Prediction,
  output logic                 Mispredict_C,
  output logic [BIT_COUNT-1:0] PCNext
);

  localparam int TAG_W = BIT_COUNT - INDEX_BITS - 2;
  localparam logic [BIT_COUNT-1:0] LSB_CLR = ~BIT_COUNT'(1);

  logic [ENTRY_COUNT-1:0] r_valid;
  logic [ENTRY_COUNT-1:0] r_jmp;
  logic [TAG_W-1:0]       r_tag    [ENTRY_COUNT];
  logic [BIT_COUNT-1:0]   r_target [ENTRY_COUNT];
  logic [1:0]             r_ctr    [ENTRY_COUNT];

  logic [INDEX_BITS-1:0]  w_lidx, w_ridx;
  logic [TAG_W-1:0]       w_ltag, w_rtag;
  logic                   w_lhit, w_rhit;
  logic [BIT_COUNT-1:0]   w_resolve_p4;
  logic [BIT_COUNT-1:0]   w_sel;
  logic                   w_unused;

  assign w_lidx = PC_I[INDEX_BITS+1:2];
  assign w_ltag = PC_I[BIT_COUNT-1:INDEX_BITS+2];
  assign w_ridx = ResolvePC_C[INDEX_BITS+1:2];
  assign w_rtag = ResolvePC_C[BIT_COUNT-1:INDEX_BITS+2];
  assign w_unused = &{1'b0, PC_I[1:0]};

  assign w_lhit = r_valid[w_lidx] && (r_tag[w_lidx] == w_ltag);
  assign w_rhit = r_valid[w_ridx] && (r_tag[w_ridx] == w_rtag);

  // Lookup reads the array before this cycle's update lands (read-before-write).
  assign Predict    = w_lhit && (r_jmp[w_lidx] || r_ctr[w_lidx][1]);
  assign Prediction = Predict ? (r_target[w_lidx] & LSB_CLR) : '0;

  // Target bit0 is ignored when comparing predicted and actual targets.
  assign Mispredict_C = Resolve_C &&
                        ((PredTaken_C != Taken_C) ||
                         (Taken_C && (((PredTarget_C ^ Target_C) & LSB_CLR) != '0)));

  assign w_resolve_p4 = ResolvePC_C + BIT_COUNT'(4);

  always_comb begin
    w_sel = PCp4;
    if (Mispredict_C)
      w_sel = Taken_C ? Target_C : w_resolve_p4;
    else if (Jump_R && !PredTaken_R)
      w_sel = PCpImm_R;
    else if (Predict)
      w_sel = Prediction;
  end

  assign PCNext = w_sel & LSB_CLR;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid <= '0;
      r_jmp   <= '0;
      for (int i = 0; i < ENTRY_COUNT; i++) begin
        r_tag[i]    <= '0;
        r_target[i] <= '0;
        r_ctr[i]    <= '0;
      end
    end else if (Resolve_C) begin
      if (w_rhit) begin
        if (Taken_C) begin
          if (r_ctr[w_ridx] != 2'b11)
            r_ctr[w_ridx] <= r_ctr[w_ridx] + 2'd1;
          r_target[w_ridx] <= Target_C;
          r_jmp[w_ridx]    <= IsJump_C;
        end else if (r_ctr[w_ridx] != 2'b00) begin
          r_ctr[w_ridx] <= r_ctr[w_ridx] - 2'd1;
        end
      end else if (Taken_C) begin
        // Allocation overwrites whatever aliased entry occupied the slot.
        r_valid[w_ridx]  <= 1'b1;
        r_tag[w_ridx]    <= w_rtag;
        r_target[w_ridx] <= Target_C;
        r_jmp[w_ridx]    <= IsJump_C;
        r_ctr[w_ridx]    <= IsJump_C ? 2'b11 : 2'b10;
      end
    end
  end

`ifdef BTB_PERF_CNT_EN
  logic [31:0] r_lookup_cnt, r_mispredict_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lookup_cnt     <= '0;
      r_mispredict_cnt <= '0;
    end else begin
      if (Resolve_C)    r_lookup_cnt     <= r_lookup_cnt + 32'd1;
      if (Mispredict_C) r_mispredict_cnt <= r_mispredict_cnt + 32'd1;
    end
  end

  assign LookupCount     = r_lookup_cnt;
  assign MispredictCount = r_mispredict_cnt;
`endif

endmodule
